opt_decryptor: RTL
==================

Name: opt_decryptor

Overview:
- Receive end of the one-time-pad link: holds up to DEPTH pads delivered over a pad-load channel, then decrypts ciphertext bytes tagged with the pad index the encryptor emitted.
- Enforces one-time use: each pad slot is invalidated on consumption, and a ciphertext byte whose slot holds no pad is flagged as an error.
- Sits between the link input pins and the downstream byte consumer, with a registered valid/ready plaintext output.

Parameters:
- WIDTH, 8, data/pad byte width
- DEPTH, 8, number of pad slots; must be a power of 2
- IDX_W, 3, index width, log2(DEPTH)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active high
- ena  in  1  block enable; when low, no accepts, loads or state changes (output register still drains)
- flush  in  1  single-cycle request to wipe all pads
- busy  out  1  high while flushing
- pad_valid  in  1  pad-load strobe (always accepted, no ready)
- pad_idx  in  IDX_W  slot to load
- pad_data  in  WIDTH  pad byte
- ct_valid  in  1  ciphertext valid
- ct_ready  out  1  ciphertext accepted when ct_valid & ct_ready
- ct_idx  in  IDX_W  pad index tagged on the byte
- ct_data  in  WIDTH  ciphertext byte
- pt_valid  out  1  plaintext valid
- pt_ready  in  1  downstream ready
- pt_data  out  WIDTH  plaintext byte
- pt_idx  out  IDX_W  pad index used
- pt_err  out  1  no pad was present for this byte
- pads_avail  out  IDX_W+1  count of loaded, unused slots
- seq_err  out  1  sticky: ct_idx deviated from the expected 0..DEPTH-1 wrap order
- err_count  out  8  saturating count of errors

Behaviour:
- Reset, synchronous on rst=1:
  - All slot valid bits = 0; pad storage = 0.
  - State = RUN; exp_idx = 0; flush pointer = 0.
  - Outputs: pt_valid=0, pt_data=0, pt_idx=0, pt_err=0, pads_avail=0, seq_err=0, err_count=0, busy=0.
- FSM states RUN and FLUSH:
  - RUN to FLUSH on ena & flush.
  - FLUSH clears slot[ptr] each ena cycle, ptr counting 0..DEPTH-1, then returns to RUN. Flush takes exactly DEPTH enabled cycles.
  - On entering FLUSH: exp_idx=0, seq_err=0, ptr=0.
  - busy = (state==FLUSH), registered.
- ct_ready = ena & (state==RUN) & (~pt_valid | pt_ready). This is the only combinational output.
- Accept cycle; the following cycle shows:
  - pt_valid=1, pt_idx=ct_idx.
  - If slot valid: pt_data = pad[ct_idx] ^ ct_data, pt_err=0.
  - Else: pt_data=0, pt_err=1.
  - slot[ct_idx] valid cleared (one-time use).
  - exp_idx = exp_idx+1 mod DEPTH.
  - seq_err set if ct_idx != exp_idx at accept.
  - Latency from accept to pt_valid is 1 cycle.
- Output hold: while pt_valid & ~pt_ready, pt_data, pt_idx and pt_err remain stable. pt_valid drops after a pt_ready cycle with no new accept. Back-to-back accepts give full throughput when pt_ready=1.
- Pad load, on ena & pad_valid & state==RUN:
  - If slot[pad_idx] was invalid at the start of the cycle: store pad_data and set valid.
  - Else drop the load and count an error. An occupied pad is never overwritten.
  - Loads during FLUSH or with ena=0 are ignored silently.
- Same-cycle load and consume of the same slot: both evaluate the pre-cycle valid bit.
  - Slot valid: consume succeeds; load is dropped (error); slot ends invalid.
  - Slot invalid: consume gives pt_err=1; load is stored; slot ends valid.
- flush asserted during FLUSH is ignored. flush and a ct accept in the same cycle: accept completes, then FLUSH begins.
- pads_avail is registered: the popcount of valid bits after the cycle's updates.
- err_count adds 1 per pt_err accept and 1 per dropped load, saturating at 255. When both occur in one cycle it adds 2, saturating.
- rst mid-flush or while pt_valid is held returns everything to reset values the next cycle; a pending output is discarded.

Test Plan:
- Load slots 0..7 with pads 8'hA5,8'h3C,...; send ct_idx 0..7 with ct_data = pt ^ pad (e.g. pt 8'h48 at idx0 so ct 8'hED) -> pt_data 8'h48 one cycle after accept; pt_err=0; pads_avail counts 8 down to 0; seq_err=0.
- Reuse: consume idx 2 twice -> second byte pt_err=1, pt_data=0, err_count=1.
- Hold pt_ready=0 for 3 cycles with ct_valid high -> ct_ready=0, pt_data stable, no second accept; release -> next byte follows on the next cycle.
- Load idx 4 twice (8'h11 then 8'h22); consume with ct 8'h11 -> pt_data 8'h00 (first pad kept), err_count=1.
- Same-cycle load and consume on empty idx 5 -> pt_err=1, slot 5 valid afterwards, pads_avail=1.
- Load 3 pads, pulse flush -> busy high 8 cycles, ct_ready=0, pads_avail=0 after; out-of-order idx (send 3 first) -> seq_err=1, then cleared by flush; rst mid-flush -> busy=0 the next cycle.

Source files
------------

// File: rtl/opt_decryptor_if.sv
// opt_decryptor_if: link-side bundle of the one-time-pad decryptor.
//   pad_valid/pad_idx/pad_data : pad-load strobe, always accepted (no ready).
//   ct_valid/ct_ready/ct_idx/ct_data : ciphertext byte channel.
//   pt_valid/pt_ready/pt_data/pt_idx/pt_err : plaintext byte channel.
//
// Handshake semantics (both ct and pt channels): a transfer happens on a
// rising clock edge where valid and ready are both high. Once valid is high
// the producer holds its payload stable until that transfer occurs. Ready may
// depend combinationally on the consumer state but never on valid.
//
// Modports: slave is the decryptor side, master is the link/consumer side.
interface opt_decryptor_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
);
  logic             pad_valid;
  logic [IDX_W-1:0] pad_idx;
  logic [WIDTH-1:0] pad_data;

  logic             ct_valid;
  logic             ct_ready;
  logic [IDX_W-1:0] ct_idx;
  logic [WIDTH-1:0] ct_data;

  logic             pt_valid;
  logic             pt_ready;
  logic [WIDTH-1:0] pt_data;
  logic [IDX_W-1:0] pt_idx;
  logic             pt_err;

  modport slave (
    input  pad_valid, pad_idx, pad_data,
    input  ct_valid, ct_idx, ct_data,
    output ct_ready,
    output pt_valid, pt_data, pt_idx, pt_err,
    input  pt_ready
  );

  modport master (
    output pad_valid, pad_idx, pad_data,
    output ct_valid, ct_idx, ct_data,
    input  ct_ready,
    input  pt_valid, pt_data, pt_idx, pt_err,
    output pt_ready
  );
endinterface

// File: rtl/opt_decryptor.sv
// opt_decryptor: receive end of a one-time-pad link.
// Holds up to DEPTH pads loaded over the pad channel and decrypts each
// ciphertext byte with the pad in the slot it is tagged with. A slot is
// invalidated when consumed, so every pad is used at most once; a byte that
// finds its slot empty is emitted as pt_err with zero data.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   ena         : block enable; low freezes accepts, loads and state
//                 (a held plaintext byte can still drain)
//   flush       : single-cycle request to wipe all pads (DEPTH enabled cycles)
//   busy        : registered, high while flushing
//   pads_avail  : registered count of loaded, unused slots
//   seq_err     : sticky, ct_idx left the 0..DEPTH-1 wrap order
//   err_count   : saturating count of empty-slot consumes and dropped loads
//   state_dbg   : current FSM state (1 = FLUSH)
//   bus         : pad / ciphertext / plaintext channels (slave side)
module opt_decryptor #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  flush,
  output logic                  busy,
  output logic [IDX_W:0]        pads_avail,
  output logic                  seq_err,
  output logic [7:0]            err_count,
  output logic                  state_dbg,
  opt_decryptor_if.slave        bus
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t           state;
  state_t           state_next;

  logic [DEPTH-1:0] slot_vld;
  logic [DEPTH-1:0] vld_next;
  logic [WIDTH-1:0] pad_mem [DEPTH];
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] exp_idx;
  logic [IDX_W:0]   avail_next;

  logic             accept;
  logic             hit;
  logic             load_en;
  logic             load_ok;
  logic             load_drop;
  logic             enter_flush;
  logic             flush_step;
  logic [1:0]       err_inc;
  logic [8:0]       err_sum;
  logic [7:0]       err_next;

  assign state_dbg = (state == FLUSH);

  // Only combinational output: a new byte is taken when running and the
  // output register is empty or being drained this cycle.
  assign bus.ct_ready = ena & (state == RUN) & (~bus.pt_valid | bus.pt_ready);
  assign accept       = bus.ct_valid & bus.ct_ready;

  // Load and consume both look at the pre-cycle valid bit of their slot.
  assign hit          = slot_vld[bus.ct_idx];
  assign load_en      = ena & bus.pad_valid & (state == RUN);
  assign load_ok      = load_en & ~slot_vld[bus.pad_idx];
  assign load_drop    = load_en &  slot_vld[bus.pad_idx];

  assign enter_flush  = ena & flush & (state == RUN);
  assign flush_step   = ena & (state == FLUSH);

  // FSM next state
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (ena && flush) state_next = FLUSH;
      FLUSH:   if (ena && (ptr == LAST_IDX)) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Slot valid bits after this cycle. The consume clear is applied before the
  // load set, so a same-slot load into an empty slot still leaves it valid,
  // while a same-slot load into a full slot was already dropped.
  always_comb begin
    vld_next = slot_vld;
    if (flush_step) vld_next[ptr] = 1'b0;
    if (accept)     vld_next[bus.ct_idx] = 1'b0;
    if (load_ok)    vld_next[bus.pad_idx] = 1'b1;
  end

  always_comb begin
    avail_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      avail_next = avail_next + (IDX_W+1)'(vld_next[i]);
    end
  end

  // Error counter: up to two events per cycle, saturating at 255.
  always_comb begin
    err_inc  = 2'(accept & ~hit) + 2'(load_drop);
    err_sum  = {1'b0, err_count} + 9'(err_inc);
    err_next = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld    <= '0;
      for (int i = 0; i < DEPTH; i++) pad_mem[i] <= '0;
      ptr         <= '0;
      exp_idx     <= '0;
      seq_err     <= 1'b0;
      busy        <= 1'b0;
      pads_avail  <= '0;
      err_count   <= '0;
      bus.pt_valid <= 1'b0;
      bus.pt_data  <= '0;
      bus.pt_idx   <= '0;
      bus.pt_err   <= 1'b0;
    end else begin
      slot_vld   <= vld_next;
      pads_avail <= avail_next;
      busy       <= (state_next == FLUSH);
      err_count  <= err_next;

      if (load_ok)    pad_mem[bus.pad_idx] <= bus.pad_data;
      if (flush_step) pad_mem[ptr] <= '0;

      if (enter_flush)     ptr <= '0;
      else if (flush_step) ptr <= ptr + IDX_W'(1);

      // Entering FLUSH restarts the expected order; it takes priority over a
      // byte accepted in the same cycle.
      if (enter_flush) begin
        exp_idx <= '0;
        seq_err <= 1'b0;
      end else if (accept) begin
        exp_idx <= exp_idx + IDX_W'(1);
        if (bus.ct_idx != exp_idx) seq_err <= 1'b1;
      end

      if (accept) begin
        bus.pt_valid <= 1'b1;
        bus.pt_idx   <= bus.ct_idx;
        bus.pt_err   <= ~hit;
        bus.pt_data  <= hit ? (pad_mem[bus.ct_idx] ^ bus.ct_data) : '0;
      end else if (bus.pt_ready) begin
        bus.pt_valid <= 1'b0;
      end
    end
  end

endmodule
